// File: rtl/flow_sched_pkg.sv
// Shared types and helpers for the flow pop scheduler.
// Optional weighted round-robin is enabled by defining FLOW_SCHED_WRR_EN.
package flow_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } sched_state_t;

    typedef logic [31:0] rank_t;
    typedef logic [31:0] value_t;

    // Widest flow vector the helpers below understand.
    localparam int MAX_FLOWS = 32;

    // Index of the set bit of a one-hot vector (last set bit if not one-hot).
    function automatic logic [4:0] onehot_to_idx(input logic [MAX_FLOWS-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_FLOWS; i++)
            if (v[i]) idx = 5'(i);
        return idx;
    endfunction

    // True when exactly one bit is set.
    function automatic logic is_onehot(input logic [MAX_FLOWS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/flow_pop_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int N  = 10,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        logic       w_found;
        logic [PW-1:0] w_idx;
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_idx     = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = PW'((int'(ptr) + i) % N);
            if (!w_found && req[w_idx]) begin
                w_found        = 1'b1;
                grant[w_idx]   = 1'b1;
                grant_idx      = w_idx;
            end
        end
    end

endmodule

// File: rtl/flow_pop_scheduler.sv
// Scheduler in front of the per-flow rank store: forwards enqueues, tracks
// per-flow occupancy, pops one non-empty flow at a time and hands the entry
// downstream on a valid/ready port. Define FLOW_SCHED_WRR_EN for weighted RR.
module flow_pop_scheduler
    import flow_sched_pkg::*;
#(
    parameter int SIZE  = 50,
    parameter int FLOWS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  rank_t            in_rank,
    input  value_t           in_value,
    input  logic [FLOWS-1:0] in_flow,
    output logic             st_push,
    output rank_t            st_push_rank,
    output value_t           st_push_value,
    output logic [FLOWS-1:0] st_push_flow,
    output logic             st_pop,
    output logic [FLOWS-1:0] st_pop_flow,
    input  logic             st_pop_valid,
    input  rank_t            st_pop_rank,
    input  value_t           st_pop_value,
    output logic             out_valid,
    input  logic             out_ready,
    output rank_t            out_rank,
    output value_t           out_value,
    output logic [FLOWS-1:0] out_flow,
`ifdef FLOW_SCHED_WRR_EN
    input  logic [FLOWS*4-1:0] weight,
`endif
    output logic             err
);

    localparam int CW = $clog2(SIZE + 1);
    localparam int FW = (FLOWS > 1) ? $clog2(FLOWS) : 1;

    logic [FLOWS-1:0][CW-1:0] r_count;
    sched_state_t             r_state;
    logic [FW-1:0]            r_ptr;
    logic [FW-1:0]            r_gnt_idx;
    logic [FLOWS-1:0]         r_gnt_flow;
    rank_t                    r_out_rank;
    value_t                   r_out_value;
    logic [FLOWS-1:0]         r_out_flow;
    logic                     r_err;

    logic                     w_in_onehot;
    logic [FW-1:0]            w_in_idx;
    logic [FLOWS-1:0]         w_req;
    logic [FLOWS-1:0]         w_grant;
    logic [FW-1:0]            w_grant_idx;
    logic                     w_pop;
    logic [FW-1:0]            w_ptr_inc;
    logic [FW-1:0]            w_ptr_next;

    assign w_in_onehot = is_onehot(MAX_FLOWS'(in_flow));
    assign w_in_idx    = FW'(onehot_to_idx(MAX_FLOWS'(in_flow)));

    // Full check uses the registered count only, so a pop in the same cycle
    // never opens a slot early.
    assign in_ready      = w_in_onehot && (r_count[w_in_idx] < CW'(SIZE));
    assign st_push       = in_valid && in_ready;
    assign st_push_rank  = in_rank;
    assign st_push_value = in_value;
    assign st_push_flow  = in_flow;

    // Request vector from registered counts: a flow pushed this cycle waits a cycle.
    always_comb begin
        for (int f = 0; f < FLOWS; f++)
            w_req[f] = (r_count[f] != '0);
    end

    rr_arbiter #(.N(FLOWS)) u_arb (
        .req       (w_req),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign w_pop       = (r_state == IDLE) && (w_req != '0);
    assign st_pop      = w_pop;
    assign st_pop_flow = w_pop ? w_grant : '0;

    assign out_valid = (r_state == HOLD);
    assign out_rank  = r_out_rank;
    assign out_value = r_out_value;
    assign out_flow  = r_out_flow;
    assign err       = r_err;

    assign w_ptr_inc = (r_gnt_idx == FW'(FLOWS - 1)) ? '0 : r_gnt_idx + 1'b1;

`ifdef FLOW_SCHED_WRR_EN
    logic [3:0] r_credit;
    logic       r_credit_vld;
    logic [3:0] w_wt;
    logic [3:0] w_credit_eff;
    logic [3:0] w_credit_rem;
    logic       w_stay;

    // Credit is loaded lazily: when the pointer lands on a flow the first
    // handshake from it starts from that flow's weight (0 counts as 1).
    assign w_wt         = (weight[{r_gnt_idx, 2'b00} +: 4] == 4'd0) ? 4'd1
                                                                   : weight[{r_gnt_idx, 2'b00} +: 4];
    assign w_credit_eff = (r_credit_vld && (r_gnt_idx == r_ptr)) ? r_credit : w_wt;
    assign w_credit_rem = w_credit_eff - 4'd1;
    assign w_stay       = (w_credit_rem != 4'd0) && (r_count[r_gnt_idx] != '0);
    assign w_ptr_next   = w_stay ? r_gnt_idx : w_ptr_inc;

    // Track remaining credit of the flow the pointer sits on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credit     <= '0;
            r_credit_vld <= 1'b0;
        end else if (r_state == HOLD && out_ready) begin
            r_credit     <= w_credit_rem;
            r_credit_vld <= w_stay;
        end
    end
`else
    assign w_ptr_next = w_ptr_inc;
`endif

    // Per-flow occupancy: +1 on accepted push, -1 on issued pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            for (int f = 0; f < FLOWS; f++) begin
                if (st_push && in_flow[f] && !(w_pop && w_grant[f]))
                    r_count[f] <= r_count[f] + 1'b1;
                else if (!(st_push && in_flow[f]) && w_pop && w_grant[f])
                    r_count[f] <= r_count[f] - 1'b1;
            end
        end
    end

    // Pop sequencing: IDLE issues, WAIT captures the store reply, HOLD hands off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_flow  <= '0;
            r_out_rank  <= '0;
            r_out_value <= '0;
            r_out_flow  <= '0;
        end else begin
            unique case (r_state)
                IDLE: if (w_pop) begin
                    r_gnt_idx  <= w_grant_idx;
                    r_gnt_flow <= w_grant;
                    r_state    <= WAIT;
                end
                WAIT: if (st_pop_valid) begin
                    r_out_rank  <= st_pop_rank;
                    r_out_value <= st_pop_value;
                    r_out_flow  <= r_gnt_flow;
                    r_state     <= HOLD;
                end else begin
                    r_state <= IDLE;
                end
                HOLD: if (out_ready) begin
                    r_ptr   <= w_ptr_next;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Sticky error: malformed push flow or a missing store reply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err <= 1'b0;
        else if ((in_valid && !w_in_onehot) || (r_state == WAIT && !st_pop_valid))
            r_err <= 1'b1;
    end

endmodule
